// File: rtl/decoder_sel_seq_if.sv
// Select-sequencer bundle: control inputs, raw button, decoder select and wrap outputs.
interface decoder_sel_seq_if;
    logic en;
    logic mode;
    logic dir;
    logic step_btn;
    logic a;
    logic b;
    logic wrap;

    modport master (
        output en, mode, dir, step_btn,
        input  a, b, wrap
    );

    modport slave (
        input  en, mode, dir, step_btn,
        output a, b, wrap
    );
endinterface

// File: rtl/decoder_sel_seq.sv
// 2-bit select sequencer for a 2-to-4 decoder: auto (prescaled) or manual
// (debounced button) stepping, up/down, with a one-cycle wrap pulse.
module decoder_sel_seq #(
    parameter int unsigned DIV     = 50000,
    parameter int unsigned DEB_CYC = 16,
    parameter int unsigned CNT_W   = 16
) (
    input logic               clk,
    input logic               rst_n,
    decoder_sel_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] PRE_MAX = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYC - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HELD   = 2'd2,
        ARM_LO = 2'd3
    } deb_state_t;

    logic             r_s1;
    logic             r_s2;
    deb_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pre;
    logic [1:0]       r_sel;
    logic             r_wrap;

    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press;
    logic             w_active;
    logic             w_auto;
    logic             w_step;
    logic [1:0]       w_sel_nxt;
    logic             w_wrap_nxt;

    // Debounce next-state; press is combinational so the step lands on the accepting edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = ARM_HI;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_HI: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == DEB_MAX) begin
                    w_state_nxt = HELD;
                    w_press     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (!r_s2) begin
                    w_state_nxt = ARM_LO;
                    w_cnt_nxt   = '0;
                end
            end
            ARM_LO: begin
                if (r_s2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == DEB_MAX) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Step selection and select arithmetic.
    assign w_active   = bus.en && !bus.mode;
    assign w_auto     = w_active && (r_pre == PRE_MAX);
    assign w_step     = w_auto || (bus.en && bus.mode && w_press);
    assign w_sel_nxt  = bus.dir ? (r_sel - 2'd1) : (r_sel + 2'd1);
    assign w_wrap_nxt = w_step && (bus.dir ? (r_sel == 2'd0) : (r_sel == 2'd3));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pre   <= '0;
            r_sel   <= 2'b00;
            r_wrap  <= 1'b0;
        end else begin
            r_s1    <= bus.step_btn;
            r_s2    <= r_s1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (!w_active || w_auto) begin
                r_pre <= '0;
            end else begin
                r_pre <= r_pre + CNT_W'(1);
            end
            if (w_step) begin
                r_sel <= w_sel_nxt;
            end
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign bus.a    = r_sel[1];
    assign bus.b    = r_sel[0];
    assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_decoder_sel_seq.sv
// Scoreboard bench: two sequencer instances (DIV=5/DEB_CYC=4 and DIV=1/DEB_CYC=1)
// share stimulus; a run-length reference model predicts {a,b,wrap} each cycle.
module tb_decoder_sel_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decoder_sel_seq_if bus0 ();
    decoder_sel_seq_if bus1 ();

    decoder_sel_seq #(.DIV(5), .DEB_CYC(4), .CNT_W(16)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    decoder_sel_seq #(.DIV(1), .DEB_CYC(1), .CNT_W(16)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [2:0] q0 [$];
    logic [2:0] q1 [$];

    // Reference model state per instance
    int p_div [2] = '{5, 1};
    int p_deb [2] = '{4, 1};
    int m_sel [2];
    int m_pre [2];
    int m_s1  [2];
    int m_s2  [2];
    int m_lvl [2];
    int m_run [2];

    // Accepted button level flips after DEB_CYC+1 consecutive synchronised
    // samples that disagree with it; a flip to 1 is a press.
    function automatic logic [2:0] model_step(input int i, input logic rst, input logic en,
                                              input logic mode, input logic dir, input logic btn);
        logic       press;
        logic       act;
        logic       auto_s;
        logic       stp;
        logic       wr;
        logic [1:0] s;
        wr = 1'b0;
        if (!rst) begin
            m_sel[i] = 0; m_pre[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
            m_lvl[i] = 0; m_run[i] = 0;
        end else begin
            press = 1'b0;
            if (m_s2[i] != m_lvl[i]) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] == p_deb[i] + 1) begin
                    m_lvl[i] = m_s2[i];
                    m_run[i] = 0;
                    press    = (m_lvl[i] == 1);
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn ? 1 : 0;
            act    = en && !mode;
            auto_s = act && (m_pre[i] == p_div[i] - 1);
            m_pre[i] = (act && !auto_s) ? m_pre[i] + 1 : 0;
            stp = auto_s || (en && mode && press);
            wr  = stp && (dir ? (m_sel[i] == 0) : (m_sel[i] == 3));
            if (stp) m_sel[i] = dir ? (m_sel[i] + 3) % 4 : (m_sel[i] + 1) % 4;
        end
        s = 2'(m_sel[i]);
        return {s, wr};
    endfunction

    task automatic drive(input logic rst, input logic en, input logic mode,
                         input logic dir, input logic btn);
        @(negedge clk);
        rst_n         = rst;
        bus0.en       = en;   bus1.en       = en;
        bus0.mode     = mode; bus1.mode     = mode;
        bus0.dir      = dir;  bus1.dir      = dir;
        bus0.step_btn = btn;  bus1.step_btn = btn;
        q0.push_back(model_step(0, rst, en, mode, dir, btn));
        q1.push_back(model_step(1, rst, en, mode, dir, btn));
    endtask

    // Monitor: outputs are registered, so each edge retires one expectation per instance.
    initial begin
        logic [2:0] exp_v;
        logic [2:0] got_v;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (q0.size() > 0) begin
                exp_v = q0.pop_front();
                got_v = {bus0.a, bus0.b, bus0.wrap};
                checks = checks + 1;
                if (got_v !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL div5_out cyc=%0d a,b,wrap got=%b required=%b", cyc, got_v, exp_v);
                end
            end
            if (q1.size() > 0) begin
                exp_v = q1.pop_front();
                got_v = {bus1.a, bus1.b, bus1.wrap};
                checks = checks + 1;
                if (got_v !== exp_v) begin
                    errors = errors + 1;
                    $display("FAIL div1_out cyc=%0d a,b,wrap got=%b required=%b", cyc, got_v, exp_v);
                end
            end
        end
    end

    initial begin
        logic en_r;
        logic mode_r;
        logic dir_r;
        logic btn_r;
        logic rst_r;
        bus0.en = 1'b1; bus0.mode = 1'b0; bus0.dir = 1'b0; bus0.step_btn = 1'b0;
        bus1.en = 1'b1; bus1.mode = 1'b0; bus1.dir = 1'b0; bus1.step_btn = 1'b0;

        // Reset with stepping enabled, then auto up through a wrap, then down
        repeat (3)  drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Manual: bounce, hold, short release, re-press, long release, press again
        repeat (2) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2)  drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (10) drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (8)  drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Enable gating mid-count, button pressed while disabled, then re-enable
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3)  drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (12) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset while armed, button kept high across release
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (8)  drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (4)  drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (2)  drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (12) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        repeat (8)  drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

        // Randomised soak
        en_r = 1'b1; mode_r = 1'b0; dir_r = 1'b0; btn_r = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            rst_r = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 39) == 0) mode_r = ~mode_r;
            if ($urandom_range(0, 29) == 0) dir_r  = ~dir_r;
            if ($urandom_range(0, 5)  == 0) btn_r  = ~btn_r;
            if ($urandom_range(0, 24) == 0) en_r   = ($urandom_range(0, 7) != 0);
            drive(rst_r, en_r, mode_r, dir_r, btn_r);
        end

        repeat (3) @(posedge clk);
        #2;
        checks = checks + 1;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain pending got=%0d required=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
